t07_mem_arbiter: RTL and testbench
==================================

// Module: t07_mem_arbiter
//
// PURPOSE
//   Shares the single external memory port between the instruction-fetch
//   requester and the data (load/store) requester. It sequences each access:
//   grant, issue, wait for memory busy to fall, capture read data, pulse done.
//   It sits between the fetch/memory stages and the external memory interface.
//   It also retries fetches that return the invalid-word sentinel, and times
//   out accesses that hang.
//
// PARAMETERS
//   INVALID_WORD  32'hDEADBEEF  sentinel read value meaning "fetch not valid"
//   MAX_RETRY     3             fetch re-issues allowed on sentinel before error
//   TIMEOUT       255           max WAIT cycles before error (8-bit counter)
//
// PORTS
//   clk        in   1   clock, rising edge
//   nrst       in   1   reset, asynchronous, active-low
//   if_req     in   1   fetch request; held until if_done
//   if_addr    in   32  fetch address (PC)
//   if_rdata   out  32  fetched instruction, valid with if_done
//   if_done    out  1   one-cycle fetch completion pulse
//   d_req      in   1   data request; held until d_done
//   d_we       in   1   1 = store, 0 = load
//   d_addr     in   32  data address
//   d_wdata    in   32  store data
//   d_sel      in   4   byte enables
//   d_rdata    out  32  load data, valid with d_done
//   d_done     out  1   one-cycle data completion pulse
//   mem_req    out  1   one-cycle access strobe to memory
//   mem_we     out  1   write enable, held through the access
//   mem_addr   out  32  access address, held
//   mem_wdata  out  32  write data, held
//   mem_sel    out  4   byte enables, held (4'hF for fetch)
//   mem_rdata  in   32  memory read data, valid when mem_busy falls
//   mem_busy   in   1   memory busy
//   err        out  1   one-cycle pulse with done on timeout or retry exhaustion
//   stall      out  1   high while any req is pending and its done not yet pulsed
//
// BEHAVIOUR
//   - Reset (async, any state): FSM -> IDLE.
//     All outputs 0; if_rdata and d_rdata = 0.
//     Retry count, timer, last_grant and busy_q are cleared.
//   - IDLE: grant the pending requester and latch its address/data/we/sel.
//     Single pending request -> that requester is granted.
//     Both pending -> data is granted, unless last_grant == data, then fetch.
//     Strict alternation under contention prevents starvation.
//     Grant -> ISSUE next cycle. No request -> stay in IDLE.
//   - ISSUE: mem_req = 1 for exactly one cycle -> WAIT. Timer cleared.
//   - WAIT: busy_q registers mem_busy.
//     Completion edge = busy_q & ~mem_busy. mem_busy low before first going
//     high is not an edge.
//     On the edge, mem_rdata is captured:
//       * fetch with rdata == INVALID_WORD and retries < MAX_RETRY:
//         retries++, -> ISSUE.
//       * otherwise -> DONE.
//     Timer increments each WAIT cycle. At TIMEOUT -> DONE with err set and
//     captured data = INVALID_WORD.
//   - DONE: one cycle. Exactly one of if_done/d_done = 1, with rdata driven.
//     err = 1 on timeout, or on sentinel after MAX_RETRY retries.
//     last_grant is updated and retries cleared -> IDLE.
//   - Minimum latency: req sampled in cycle 0; mem_req in cycle 1.
//     With a 1-cycle busy pulse (cycle 2), done is in cycle 4.
//   - mem_* address/data/we/sel stay stable from ISSUE through DONE.
//     They hold their last value in IDLE.
//   - A req dropped mid-access does not abort it; done still pulses once.
//   - Store: d_rdata = captured mem_rdata (don't-care for the consumer).
//   - stall = (if_req | d_req) & ~(if_done | d_done).
//
// TESTING
//   1. Lone fetch: if_addr=0x100, busy high 1 cycle, rdata=0x00500093
//      -> mem_req at cycle 1; if_done + if_rdata=0x00500093 at cycle 4;
//      d_done stays 0.
//   2. Simultaneous if_req + d_req (load 0x2000), after reset
//      -> data served first, then fetch.
//      Back-to-back contention alternates d, if, d, if.
//   3. Fetch returns 0xDEADBEEF twice, then 0x13
//      -> 3 mem_req strobes total; single if_done with 0x13; err=0.
//      Returns sentinel 4 times -> if_done with err=1.
//   4. Store d_we=1, d_sel=4'b0011, d_wdata=0xCAFE
//      -> mem_we=1, mem_sel=0011, mem_wdata=0xCAFE held until d_done.
//   5. mem_busy stuck high -> d_done + err at WAIT cycle 255,
//      d_rdata=0xDEADBEEF; FSM then returns to IDLE.
//   6. nrst low during WAIT -> all outputs 0 immediately.
//      After release, a new fetch completes normally.

Source files
------------

// File: rtl/t07_mem_arbiter_if.sv
// rtl/t07_mem_arbiter_if.sv - fetch/data requester and external memory bus bundle
interface t07_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_sel;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata;
    logic        mem_busy;
    logic        err;
    logic        stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_sel, mem_rdata, mem_busy,
        output if_rdata, if_done, d_rdata, d_done,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_sel, err, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_sel, mem_rdata, mem_busy,
        input  if_rdata, if_done, d_rdata, d_done,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_sel, err, stall
    );
endinterface

// File: rtl/t07_mem_arbiter.sv
// rtl/t07_mem_arbiter.sv - fetch/data arbiter for the single external memory port
module t07_mem_arbiter #(
    parameter logic [31:0] INVALID_WORD = 32'hDEADBEEF,
    parameter int          MAX_RETRY    = 3,
    parameter int          TIMEOUT      = 255
) (
    input  logic             clk,
    input  logic             nrst,
    t07_mem_arbiter_if.slave bus
);
    localparam int RW = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t        r_state;
    logic          r_gnt_d;
    logic          r_last_d;
    logic          r_busy_q;
    logic [RW-1:0] r_retry;
    logic [7:0]    r_timer;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_sel;
    logic          r_if_done;
    logic          r_d_done;
    logic          r_err;
    logic [31:0]   r_if_rdata;
    logic [31:0]   r_d_rdata;

    logic          w_edge;
    logic          w_sentinel;
    logic          w_retry;
    logic          w_grant_d;
    logic          w_cap_err;
    logic [31:0]   w_cap_data;

    // busy_q is cleared on every issue, so busy low before it first rises never looks like completion
    assign w_edge     = r_busy_q & ~bus.mem_busy;
    assign w_sentinel = ~r_gnt_d & (bus.mem_rdata == INVALID_WORD);
    assign w_retry    = w_edge & w_sentinel & (r_retry < RW'(MAX_RETRY));
    assign w_cap_data = w_edge ? bus.mem_rdata : INVALID_WORD;
    assign w_cap_err  = ~w_edge | w_sentinel;
    // data wins contention unless it was served last
    assign w_grant_d  = bus.d_req & (~bus.if_req | ~r_last_d);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_gnt_d     <= 1'b0;
            r_last_d    <= 1'b0;
            r_busy_q    <= 1'b0;
            r_retry     <= '0;
            r_timer     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_sel   <= '0;
            r_if_done   <= 1'b0;
            r_d_done    <= 1'b0;
            r_err       <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_mem_req <= 1'b0;
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        r_gnt_d     <= 1'b1;
                        r_mem_we    <= bus.d_we;
                        r_mem_addr  <= bus.d_addr;
                        r_mem_wdata <= bus.d_wdata;
                        r_mem_sel   <= bus.d_sel;
                        r_mem_req   <= 1'b1;
                        r_state     <= S_ISSUE;
                    end else if (bus.if_req) begin
                        r_gnt_d     <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= bus.if_addr;
                        r_mem_wdata <= '0;
                        r_mem_sel   <= 4'hF;
                        r_mem_req   <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_timer  <= '0;
                    r_busy_q <= 1'b0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    r_busy_q <= bus.mem_busy;
                    r_timer  <= r_timer + 8'd1;
                    if (w_retry) begin
                        r_retry   <= r_retry + RW'(1);
                        r_mem_req <= 1'b1;
                        r_state   <= S_ISSUE;
                    end else if (w_edge || r_timer == 8'(TIMEOUT - 1)) begin
                        if (r_gnt_d) begin
                            r_d_done  <= 1'b1;
                            r_d_rdata <= w_cap_data;
                        end else begin
                            r_if_done  <= 1'b1;
                            r_if_rdata <= w_cap_data;
                        end
                        r_err   <= w_cap_err;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_last_d <= r_gnt_d;
                    r_retry  <= '0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_sel   = r_mem_sel;
    assign bus.if_done   = r_if_done;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_done    = r_d_done;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.err       = r_err;
    assign bus.stall     = (bus.if_req | bus.d_req) & ~(r_if_done | r_d_done);
endmodule

// File: tb/tb_t07_mem_arbiter.sv
// tb/tb_t07_mem_arbiter.sv - directed scoreboard bench for t07_mem_arbiter
module tb_t07_mem_arbiter;
    logic clk = 1'b0;
    logic nrst;

    always #5 clk = ~clk;

    t07_mem_arbiter_if bus ();

    t07_mem_arbiter #(
        .INVALID_WORD(32'hDEADBEEF),
        .MAX_RETRY   (3),
        .TIMEOUT     (255)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    typedef struct {
        int          busy;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
        logic        err;
        logic [31:0] addr;
    } exp_t;

    resp_t resp_q[$];
    exp_t  sb[$];
    int    tests    = 0;
    int    fails    = 0;
    int    done_cnt = 0;
    int    strobes  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic add_resp(input int busy, input logic [31:0] data);
        resp_q.push_back('{busy, data});
    endtask

    task automatic expect_acc(input logic is_d, input logic [31:0] addr,
                              input logic [31:0] data, input logic err);
        sb.push_back('{is_d, data, err, addr});
    endtask

    task automatic wait_done(input int max_cycles, input string tag);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, done_cnt - start, 1);
    endtask

    // memory model: busy rises the cycle after the strobe, falls with data after resp.busy cycles
    initial begin
        resp_t r;
        bus.mem_busy  = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (nrst === 1'b1 && bus.mem_req === 1'b1) begin
                strobes++;
                if (resp_q.size() > 0) r = resp_q.pop_front();
                else r = '{1, 32'h0};
                @(posedge clk);
                #1 bus.mem_busy = 1'b1;
                for (int i = 0; i < r.busy; i++) begin
                    @(posedge clk);
                    if (nrst !== 1'b1) break;
                end
                #1;
                bus.mem_busy  = 1'b0;
                bus.mem_rdata = r.data;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.if_done === 1'b1 || bus.d_done === 1'b1) begin
                done_cnt++;
                check("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("done_src", {bus.d_done, bus.if_done}, e.is_d ? 2'b10 : 2'b01);
                    check("rdata", e.is_d ? bus.d_rdata : bus.if_rdata, e.data);
                    check("err", bus.err, e.err);
                    check("mem_addr", bus.mem_addr, e.addr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        nrst        = 1'b0;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_sel   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_mem_sel", bus.mem_sel, 0);
        check("rst_if_done", bus.if_done, 0);
        check("rst_d_done", bus.d_done, 0);
        check("rst_err", bus.err, 0);
        check("rst_stall", bus.stall, 0);
        check("rst_if_rdata", bus.if_rdata, 0);
        check("rst_d_rdata", bus.d_rdata, 0);
        @(negedge clk) nrst = 1'b1;
        @(posedge clk);
        #1;

        // lone fetch, minimum latency
        add_resp(1, 32'h00500093);
        expect_acc(1'b0, 32'h100, 32'h00500093, 1'b0);
        bus.if_addr = 32'h100;
        bus.if_req  = 1'b1;
        #1 check("t1_stall_pending", bus.stall, 1);
        @(posedge clk); #1;
        check("t1_mem_req_c1", bus.mem_req, 1);
        check("t1_mem_addr", bus.mem_addr, 32'h100);
        check("t1_mem_sel", bus.mem_sel, 4'hF);
        check("t1_mem_we", bus.mem_we, 0);
        @(posedge clk); #1;
        check("t1_mem_req_c2", bus.mem_req, 0);
        @(posedge clk); #1;
        check("t1_if_done_c3", bus.if_done, 0);
        @(posedge clk); #1;
        check("t1_if_done_c4", bus.if_done, 1);
        check("t1_d_done_c4", bus.d_done, 0);
        check("t1_stall_done", bus.stall, 0);
        bus.if_req = 1'b0;
        @(posedge clk); #1;
        check("t1_if_done_c5", bus.if_done, 0);

        // contention: d, if, d, if
        add_resp(1, 32'hD0000001);
        add_resp(1, 32'h10000002);
        add_resp(2, 32'hD0000003);
        add_resp(1, 32'h10000004);
        expect_acc(1'b1, 32'h2000, 32'hD0000001, 1'b0);
        expect_acc(1'b0, 32'h104,  32'h10000002, 1'b0);
        expect_acc(1'b1, 32'h2000, 32'hD0000003, 1'b0);
        expect_acc(1'b0, 32'h104,  32'h10000004, 1'b0);
        bus.d_addr  = 32'h2000;
        bus.d_we    = 1'b0;
        bus.d_sel   = 4'hF;
        bus.if_addr = 32'h104;
        bus.d_req   = 1'b1;
        bus.if_req  = 1'b1;
        repeat (4) wait_done(20, "t2_done");
        bus.d_req  = 1'b0;
        bus.if_req = 1'b0;

        // sentinel twice then good word
        strobes = 0;
        add_resp(1, 32'hDEADBEEF);
        add_resp(1, 32'hDEADBEEF);
        add_resp(1, 32'h00000013);
        expect_acc(1'b0, 32'h200, 32'h00000013, 1'b0);
        bus.if_addr = 32'h200;
        bus.if_req  = 1'b1;
        wait_done(40, "t3a_done");
        bus.if_req = 1'b0;
        check("t3a_strobes", strobes, 3);

        // sentinel four times: retries exhausted
        @(posedge clk); #1;
        strobes = 0;
        repeat (4) add_resp(1, 32'hDEADBEEF);
        expect_acc(1'b0, 32'h204, 32'hDEADBEEF, 1'b1);
        bus.if_addr = 32'h204;
        bus.if_req  = 1'b1;
        wait_done(50, "t3b_done");
        bus.if_req = 1'b0;
        check("t3b_strobes", strobes, 4);

        // store with partial byte enables, held through done
        @(posedge clk); #1;
        add_resp(3, 32'h00000055);
        expect_acc(1'b1, 32'h3000, 32'h00000055, 1'b0);
        bus.d_we    = 1'b1;
        bus.d_sel   = 4'b0011;
        bus.d_wdata = 32'h0000CAFE;
        bus.d_addr  = 32'h3000;
        bus.d_req   = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            check("t4_mem_we", bus.mem_we, 1);
            check("t4_mem_sel", bus.mem_sel, 4'b0011);
            check("t4_mem_wdata", bus.mem_wdata, 32'h0000CAFE);
        end
        check("t4_d_done_c6", bus.d_done, 1);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        bus.d_sel = 4'hF;

        // busy stuck: timeout on the 255th wait cycle
        @(posedge clk); #1;
        strobes = 0;
        add_resp(300, 32'h00001234);
        expect_acc(1'b1, 32'h4000, 32'hDEADBEEF, 1'b1);
        bus.d_addr = 32'h4000;
        bus.d_req  = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.d_done !== 1'b1 && n < 400);
        check("t5_timeout_cycle", n, 257);
        bus.d_req = 1'b0;
        n = 0;
        while (bus.mem_busy === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_busy_released", bus.mem_busy, 0);
        @(posedge clk); #1;
        check("t5_no_extra_strobe", strobes, 1);
        check("t5_stall_idle", bus.stall, 0);

        // async reset mid-WAIT
        strobes = 0;
        add_resp(20, 32'h00000077);
        bus.if_addr = 32'h500;
        bus.if_req  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nrst       = 1'b0;
        bus.if_req = 1'b0;
        #1;
        check("t6_rst_mem_req", bus.mem_req, 0);
        check("t6_rst_mem_we", bus.mem_we, 0);
        check("t6_rst_mem_addr", bus.mem_addr, 0);
        check("t6_rst_mem_wdata", bus.mem_wdata, 0);
        check("t6_rst_mem_sel", bus.mem_sel, 0);
        check("t6_rst_if_done", bus.if_done, 0);
        check("t6_rst_d_done", bus.d_done, 0);
        check("t6_rst_err", bus.err, 0);
        check("t6_rst_if_rdata", bus.if_rdata, 0);
        check("t6_rst_d_rdata", bus.d_rdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) nrst = 1'b1;
        n = 0;
        while (bus.mem_busy === 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        strobes = 0;
        add_resp(2, 32'h0000ABCD);
        expect_acc(1'b0, 32'h600, 32'h0000ABCD, 1'b0);
        bus.if_addr = 32'h600;
        bus.if_req  = 1'b1;
        wait_done(20, "t6_done");
        bus.if_req = 1'b0;
        check("t6_strobes", strobes, 1);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
